spi_slave_regs: RTL
===================

Name: spi_slave_regs

Overview:
- SPI responder for the serial register link driven by the team's SPI master. It sits on the peripheral/codec side.
- Oversamples sck, ss_n and mosi in its single system clock domain and decodes frames of the form {R/W flag + address, data}, MSB first.
- Turns each complete frame into a single-cycle write strobe or a read fetch on a local register bus. Read data is shifted back on miso.

Parameters:
- ADDR_BITS, 8, on-wire address field width (8 or 16); the field's MSB is the read flag (1 = read).
- DATA_BITS, 16, on-wire data field width (8 or 16).
- SYNC_STAGES, 2, synchronizer depth for sck, ss_n and mosi (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the sck frequency.
- reset  in  1  asynchronous, active-low reset.
- sck  in  1  serial clock from the master; idles low; mosi is stable at the sck rising edge.
- ss_n  in  1  active-low frame select.
- mosi  in  1  serial data from the master.
- miso  out  1  serial read data to the master.
- reg_addr  out  ADDR_BITS-1  register address (read flag stripped).
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_data  out  DATA_BITS  write data; valid while reg_wr_en is high.
- reg_rd_en  out  1  one-cycle read request.
- reg_rd_data  in  DATA_BITS  read data; sampled exactly 1 clk after reg_rd_en.
- busy  out  1  high while a frame is in progress (ss_n synchronized low).
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (reset=0): all outputs 0; state=IDLE; shift register and bit counter cleared. Reset is asynchronous and takes effect mid-frame with no bus strobe.
- Synchronization and edge detection:
  - sck, ss_n and mosi each pass through SYNC_STAGES flops.
  - sck_rise/sck_fall come from the last stage versus a delayed copy.
  - ss_fall/ss_rise are derived the same way.
  - mosi is sampled from the synchronized copy on sck_rise.
- IDLE:
  - ss_fall -> ADDR; bit_cnt=ADDR_BITS-1; shift register cleared; miso=0.
  - sck edges while ss_n is high are ignored.
- ADDR:
  - Each sck_rise shifts mosi into shreg at the LSB.
  - When bit_cnt=0 on sck_rise: reg_addr = the lower ADDR_BITS-1 bits of the assembled address.
    - Flag=1 -> RD_FETCH.
    - Flag=0 -> WR_DATA with bit_cnt=DATA_BITS-1.
- RD_FETCH:
  - Assert reg_rd_en for 1 cycle.
  - Next cycle: load rd_shreg from reg_rd_data and go to RD_SHIFT.
  - Total fetch latency is 2 clk, which fits inside the half-sck window guaranteed by the 8x ratio.
- RD_SHIFT:
  - On the first sck_fall after entry: miso = rd_shreg[DATA_BITS-1].
  - Each later sck_fall shifts out the next bit, MSB first.
  - After DATA_BITS bits have been driven, the following sck_fall sets miso=0 -> WAIT_SS.
  - The master samples at sck_fall, so each bit is held for one full sck period.
- WR_DATA:
  - Each sck_rise shifts in mosi.
  - When bit_cnt=0: the next clk pulses reg_wr_en with reg_wr_data = the assembled word -> WAIT_SS.
- WAIT_SS:
  - Any further sck edges (trailing ss hold cycles) are ignored. miso=0.
  - ss_rise -> IDLE.
- Abort: ss_rise in any state other than IDLE/WAIT_SS -> IDLE immediately. No reg_wr_en is issued. A reg_rd_en already issued is not retracted.
- Simultaneous events: ss_rise takes priority over a same-cycle sck edge. An ss_fall arriving in the cycle after an ss_rise starts a new frame normally.
- One register access per frame. Extra bits after the data field are ignored, never treated as a second frame.
- busy = synchronized ss_n is low.
- reg_addr holds its value until the next frame's address completes.

Optional Feature:
- Macro: SPI_SLAVE_ABORT_STATS_EN.
- With the macro: adds outputs abort_pulse (1 bit) and abort_count (8 bits, saturating at 255, reset 0).
  - abort_pulse is high for 1 clk on every abort as defined above.
  - abort_count increments on the same cycle.
- Without the macro: neither port exists, and abort handling is otherwise identical.

Decomposition:
- Package spi_pkg holds:
  - state enum (IDLE=0, ADDR=1, RD_FETCH=2, RD_SHIFT=3, WR_DATA=4, WAIT_SS=5);
  - READ_FLAG_BIT convention (MSB of the address field);
  - minimum clock-ratio constant (8).
- Sub-module spi_sync_edge: parameterized SYNC_STAGES synchronizer plus rise/fall detector, instantiated 3 times (sck, ss_n, mosi; the mosi instance's edge outputs are unused).

Test Plan:
- Write: ADDR_BITS=8, DATA_BITS=16, frame 0x12 then 0xBEEF -> exactly one reg_wr_en with reg_addr=0x12, reg_wr_data=0xBEEF; no reg_rd_en.
- Read: frame 0x85 with reg_rd_data model returning 0xA55A for addr 0x05 -> reg_rd_en once, reg_addr=0x05; miso bits sampled on sck falls = 1010_0101_0101_1010.
- Abort: ss_n deasserted after 10 of 24 bits of a write -> no reg_wr_en; state returns to IDLE; next full write 0x01/0x0001 completes correctly; with SPI_SLAVE_ABORT_STATS_EN, abort_count=1.
- Trailing clocks: master holds ss_n low for 32 sck cycles on a 24-bit write -> exactly one reg_wr_en; miso stays 0.
- Reset mid-frame: reset pulled low during RD_SHIFT -> miso=0, state=IDLE immediately; no strobes after release.
- 16-bit address: ADDR_BITS=16, DATA_BITS=8, frame 0x8123 -> reg_rd_en with reg_addr=0x0123; 8 data bits returned MSB first.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-link responder.
package spi_pkg;

  // FSM states; the encoding is exported on the debug 'state' port.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    RD_FETCH = 3'd2,
    RD_SHIFT = 3'd3,
    WR_DATA  = 3'd4,
    WAIT_SS  = 3'd5
  } spi_state_e;

  // The system clock must run at least this many times faster than sck.
  localparam int MIN_CLK_RATIO = 8;

  // The read flag is the MSB of the on-wire address field.
  function automatic int read_flag_bit(input int addr_bits);
    return addr_bits - 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall detection on the synchronized level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  // Shift the raw input through the chain; keep one delayed copy of the last stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  // Register the chain; reset to the line's idle level so no false edge follows reset.
  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~dly_q;
  assign fall = ~dout & dly_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI responder: decodes {R/W flag + address, data} frames into local register
// bus strobes and shifts read data back on miso.
// Optional build macro SPI_SLAVE_ABORT_STATS_EN adds abort_pulse/abort_count.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sck,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [ADDR_BITS-2:0] reg_addr,
  output logic                 reg_wr_en,
  output logic [DATA_BITS-1:0] reg_wr_data,
  output logic                 reg_rd_en,
  input  logic [DATA_BITS-1:0] reg_rd_data,
  output logic                 busy,
  output logic [2:0]           state
`ifdef SPI_SLAVE_ABORT_STATS_EN
  ,
  output logic                 abort_pulse,
  output logic [7:0]           abort_count
`endif
);

  localparam int SH_W   = max2(ADDR_BITS, DATA_BITS);
  localparam int CNT_W  = $clog2(SH_W + 1);
  localparam int RD_FLAG = read_flag_bit(ADDR_BITS);

  // Synchronized levels and edges
  logic sck_s, sck_rise, sck_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(reset), .din(sck),
    .dout(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  // ss_n idles high, so its chain resets high to avoid a phantom frame start.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(reset), .din(ss_n),
    .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(reset), .din(mosi),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // State and datapath registers
  spi_state_e           state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SH_W-1:0]      shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rd_shreg_q, rd_shreg_d;
  logic                 fetch_q, fetch_d;
  logic                 miso_q, miso_d;
  logic [ADDR_BITS-2:0] reg_addr_q, reg_addr_d;
  logic                 reg_wr_en_q, reg_wr_en_d;
  logic [DATA_BITS-1:0] reg_wr_data_q, reg_wr_data_d;
  logic                 reg_rd_en_q, reg_rd_en_d;

  logic [SH_W-1:0]      shifted;
  logic                 abort;

  // sck is ignored while sck_s is only needed for edges.
  assign shifted = {shreg_q[SH_W-2:0], mosi_s};
  // ss_rise mid-transfer aborts; it wins over any same-cycle sck edge.
  assign abort   = ss_rise && (state_q inside {ADDR, RD_FETCH, RD_SHIFT, WR_DATA});

  // Next-state and datapath update for the frame decoder.
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    rd_shreg_d    = rd_shreg_q;
    fetch_d       = fetch_q;
    miso_d        = miso_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_en_d   = 1'b0;
    reg_wr_data_d = reg_wr_data_q;
    reg_rd_en_d   = 1'b0;

    if (abort) begin
      state_d = IDLE;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (ss_fall) begin
            state_d   = ADDR;
            bit_cnt_d = CNT_W'(ADDR_BITS - 1);
            shreg_d   = '0;
          end
        end
        ADDR: begin
          if (sck_rise) begin
            shreg_d = shifted;
            if (bit_cnt_q == '0) begin
              reg_addr_d = shifted[ADDR_BITS-2:0];
              shreg_d    = '0;
              if (shifted[RD_FLAG]) begin
                state_d     = RD_FETCH;
                reg_rd_en_d = 1'b1;
                fetch_d     = 1'b0;
              end else begin
                state_d   = WR_DATA;
                bit_cnt_d = CNT_W'(DATA_BITS - 1);
              end
            end else begin
              bit_cnt_d = bit_cnt_q - CNT_W'(1);
            end
          end
        end
        RD_FETCH: begin
          // First cycle: reg_rd_en is on the bus. Second: capture the returned data.
          if (!fetch_q) begin
            fetch_d = 1'b1;
          end else begin
            rd_shreg_d = reg_rd_data;
            bit_cnt_d  = CNT_W'(DATA_BITS);
            state_d    = RD_SHIFT;
          end
        end
        RD_SHIFT: begin
          if (sck_fall) begin
            if (bit_cnt_q != '0) begin
              miso_d     = rd_shreg_q[DATA_BITS-1];
              rd_shreg_d = {rd_shreg_q[DATA_BITS-2:0], 1'b0};
              bit_cnt_d  = bit_cnt_q - CNT_W'(1);
            end else begin
              miso_d  = 1'b0;
              state_d = WAIT_SS;
            end
          end
        end
        WR_DATA: begin
          if (sck_rise) begin
            shreg_d = shifted;
            if (bit_cnt_q == '0) begin
              reg_wr_en_d   = 1'b1;
              reg_wr_data_d = shifted[DATA_BITS-1:0];
              state_d       = WAIT_SS;
            end else begin
              bit_cnt_d = bit_cnt_q - CNT_W'(1);
            end
          end
        end
        WAIT_SS: begin
          miso_d = 1'b0;
          if (ss_rise) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  // Frame decoder registers; every flop, including the shift registers, resets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      rd_shreg_q    <= '0;
      fetch_q       <= 1'b0;
      miso_q        <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_data_q <= '0;
      reg_rd_en_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      rd_shreg_q    <= rd_shreg_d;
      fetch_q       <= fetch_d;
      miso_q        <= miso_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_data_q <= reg_wr_data_d;
      reg_rd_en_q   <= reg_rd_en_d;
    end
  end

  assign miso        = miso_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_en   = reg_wr_en_q;
  assign reg_wr_data = reg_wr_data_q;
  assign reg_rd_en   = reg_rd_en_q;
  assign busy        = ~ss_s;
  assign state       = state_q;

`ifdef SPI_SLAVE_ABORT_STATS_EN
  logic       abort_pulse_q, abort_pulse_d;
  logic [7:0] abort_count_q, abort_count_d;

  // Pulse and saturating count of aborted frames.
  always_comb begin
    abort_pulse_d = abort;
    abort_count_d = abort_count_q;
    if (abort && (abort_count_q != 8'hFF)) abort_count_d = abort_count_q + 8'd1;
  end

  // Abort statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      abort_pulse_q <= 1'b0;
      abort_count_q <= '0;
    end else begin
      abort_pulse_q <= abort_pulse_d;
      abort_count_q <= abort_count_d;
    end
  end

  assign abort_pulse = abort_pulse_q;
  assign abort_count = abort_count_q;
`endif

endmodule
